// File: rtl/usb_tx_sequencer.sv
// rtl/usb_tx_sequencer.sv - USB host transmit sequencer: token load, inter-packet gap, DATA0 load, EOP wait with watchdog.
module usb_tx_sequencer #(
  parameter int IPG_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_is_out,
  input  logic [6:0]  cmd_addr,
  input  logic [3:0]  cmd_endp,
  input  logic [63:0] cmd_data,
  output logic [18:0] crc5_pkt_in,
  output logic        crc5_pkt_ready,
  output logic [71:0] crc16_pkt_in,
  output logic        crc16_pkt_ready,
  input  logic        pkt_done,
  output logic        busy,
  output logic        seq_done,
  output logic        seq_error
);

  localparam logic [7:0]  LP_IPG_LAST = 8'(IPG_CYCLES - 1);
  localparam logic [15:0] LP_TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  LP_PID_OUT  = 8'hE1;
  localparam logic [7:0]  LP_PID_IN   = 8'h69;
  localparam logic [7:0]  LP_PID_DAT0 = 8'hC3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOK_LOAD,
    S_TOK_WAIT,
    S_GAP,
    S_DAT_LOAD,
    S_DAT_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_is_out;
  logic [18:0] r_crc5_pkt;
  logic [71:0] r_crc16_pkt;
  logic [15:0] r_timer;
  logic [7:0]  r_gap;
  logic        w_accept;
  logic        w_waiting;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign w_waiting = (r_state == S_TOK_WAIT) || (r_state == S_DAT_WAIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // pkt_done wins over a timer expiry landing in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (cmd_valid) w_state_nxt = S_TOK_LOAD;
      S_TOK_LOAD: w_state_nxt = S_TOK_WAIT;
      S_TOK_WAIT: begin
        if (pkt_done)                   w_state_nxt = r_is_out ? S_GAP : S_DONE;
        else if (r_timer == LP_TO_LAST) w_state_nxt = S_ERR;
      end
      S_GAP:      if (r_gap == LP_IPG_LAST) w_state_nxt = S_DAT_LOAD;
      S_DAT_LOAD: w_state_nxt = S_DAT_WAIT;
      S_DAT_WAIT: begin
        if (pkt_done)                   w_state_nxt = S_DONE;
        else if (r_timer == LP_TO_LAST) w_state_nxt = S_ERR;
      end
      S_DONE:     w_state_nxt = S_IDLE;
      S_ERR:      w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_is_out    <= 1'b0;
      r_crc5_pkt  <= '0;
      r_crc16_pkt <= '0;
    end else if (w_accept) begin
      r_is_out    <= cmd_is_out;
      r_crc5_pkt  <= {cmd_endp, cmd_addr, (cmd_is_out ? LP_PID_OUT : LP_PID_IN)};
      r_crc16_pkt <= {cmd_data, LP_PID_DAT0};
    end
  end

  // Timer starts at 0 in the first wait cycle, so it reads N-1 in the N-th wait cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if ((r_state == S_TOK_LOAD) || (r_state == S_DAT_LOAD)) begin
      r_timer <= '0;
    end else if (w_waiting && (r_timer != 16'hFFFF)) begin
      r_timer <= r_timer + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gap <= '0;
    end else if (r_state == S_TOK_WAIT) begin
      r_gap <= '0;
    end else if (r_state == S_GAP) begin
      r_gap <= r_gap + 8'd1;
    end
  end

  assign cmd_ready       = (r_state == S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign crc5_pkt_ready  = (r_state == S_TOK_LOAD);
  assign crc16_pkt_ready = (r_state == S_DAT_LOAD);
  assign seq_done        = (r_state == S_DONE);
  assign seq_error       = (r_state == S_ERR);
  assign crc5_pkt_in     = r_crc5_pkt;
  assign crc16_pkt_in    = r_crc16_pkt;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// tb/tb_usb_tx_sequencer.sv - directed self-checking bench for usb_tx_sequencer.
module tb_usb_tx_sequencer;

  logic        clock;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_is_out;
  logic [6:0]  cmd_addr;
  logic [3:0]  cmd_endp;
  logic [63:0] cmd_data;
  logic [18:0] crc5_pkt_in;
  logic        crc5_pkt_ready;
  logic [71:0] crc16_pkt_in;
  logic        crc16_pkt_ready;
  logic        pkt_done;
  logic        busy;
  logic        seq_done;
  logic        seq_error;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_c5   = 0;
  int cnt_c16  = 0;
  int cnt_done = 0;
  int cnt_err  = 0;
  int both_hi  = 0;

  usb_tx_sequencer #(.IPG_CYCLES(4), .TIMEOUT_CYCLES(512)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_is_out      (cmd_is_out),
    .cmd_addr        (cmd_addr),
    .cmd_endp        (cmd_endp),
    .cmd_data        (cmd_data),
    .crc5_pkt_in     (crc5_pkt_in),
    .crc5_pkt_ready  (crc5_pkt_ready),
    .crc16_pkt_in    (crc16_pkt_in),
    .crc16_pkt_ready (crc16_pkt_ready),
    .pkt_done        (pkt_done),
    .busy            (busy),
    .seq_done        (seq_done),
    .seq_error       (seq_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n) begin
      if (crc5_pkt_ready)                    cnt_c5++;
      if (crc16_pkt_ready)                   cnt_c16++;
      if (seq_done)                          cnt_done++;
      if (seq_error)                         cnt_err++;
      if (crc5_pkt_ready && crc16_pkt_ready) both_hi++;
    end
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic o, input logic [6:0] a, input logic [3:0] e,
                          input logic [63:0] d);
    int n;
    n = 0;
    cmd_is_out = o;
    cmd_addr   = a;
    cmd_endp   = e;
    cmd_data   = d;
    while (!cmd_ready && n < 100) begin
      n++;
      tick();
    end
    chk("accept_wait", 72'(n < 100), 72'd1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_done();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
  endtask

  initial begin
    int g;
    int w;
    int c5, c16, dn, er;
    int rdy_seen;
    logic [63:0] d_out;
    d_out      = 64'h40aa11b7682df6d8;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_is_out = 1'b0;
    cmd_addr   = '0;
    cmd_endp   = '0;
    cmd_data   = '0;
    pkt_done   = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_cmd_ready", 72'(cmd_ready), 72'd1);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_crc5_in", 72'(crc5_pkt_in), 72'd0);
    chk("rst_crc16_in", crc16_pkt_in, 72'd0);
    chk("rst_done_err", 72'({seq_done, seq_error}), 72'd0);

    // Reset asserted in the middle of the inter-packet gap.
    send_cmd(1'b1, 7'd5, 7'd4, d_out);
    chk("gapabort_strobe", 72'(crc5_pkt_ready), 72'd1);
    repeat (3) tick();
    pulse_done();
    tick();
    c16 = cnt_c16; dn = cnt_done; er = cnt_err;
    chk("gapabort_busy_pre", 72'(busy), 72'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_cmd_ready", 72'(cmd_ready), 72'd1);
    chk("abort_busy", 72'(busy), 72'd0);
    chk("abort_crc5_in", 72'(crc5_pkt_in), 72'd0);
    chk("abort_crc16_in", crc16_pkt_in, 72'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_strobes", 72'({crc5_pkt_ready, crc16_pkt_ready}), 72'd0);
    chk("post_rst_ready", 72'(cmd_ready), 72'd1);
    repeat (8) tick();
    chk("abort_no_events", 72'({cnt_c16 - c16, cnt_done - dn, cnt_err - er}), 72'd0);

    // IN command; stray pkt_done in IDLE beforehand.
    pulse_done();
    chk("stray_idle_busy", 72'(busy), 72'd0);
    chk("stray_idle_ready", 72'(cmd_ready), 72'd1);
    c5 = cnt_c5; c16 = cnt_c16; dn = cnt_done;
    send_cmd(1'b0, 7'd5, 4'd8, 64'h0);
    chk("in_crc5_in", 72'(crc5_pkt_in), 72'(19'b1000_0000101_01101001));
    chk("in_strobe", 72'(crc5_pkt_ready), 72'd1);
    repeat (40) tick();
    chk("in_busy_wait", 72'({busy, seq_done}), 72'b10);
    pulse_done();
    chk("in_seq_done", 72'(seq_done), 72'd1);
    chk("in_not_ready", 72'(cmd_ready), 72'd0);
    tick();
    chk("in_done_pulse", 72'(seq_done), 72'd0);
    chk("in_ready_back", 72'(cmd_ready), 72'd1);
    chk("in_counts", 72'({8'(cnt_c5 - c5), 8'(cnt_c16 - c16), 8'(cnt_done - dn)}),
        72'({8'd1, 8'd0, 8'd1}));

    // OUT command with a stray pkt_done inside the gap.
    c5 = cnt_c5; c16 = cnt_c16; dn = cnt_done;
    send_cmd(1'b1, 7'd5, 4'd4, d_out);
    chk("out_crc5_in", 72'(crc5_pkt_in), 72'(19'b0100_0000101_11100001));
    repeat (10) tick();
    pulse_done();
    g = 0;
    while (!crc16_pkt_ready && g < 20) begin
      g++;
      pkt_done = (g == 2);
      tick();
    end
    pkt_done = 1'b0;
    chk("out_gap_len", 72'(g), 72'd4);
    chk("out_crc16_strobe", 72'(crc16_pkt_ready), 72'd1);
    chk("out_crc16_in", crc16_pkt_in, 72'h40aa11b7682df6d8_C3);
    tick();
    chk("out_crc16_one", 72'(crc16_pkt_ready), 72'd0);
    repeat (5) tick();
    pulse_done();
    chk("out_seq_done", 72'(seq_done), 72'd1);
    tick();
    chk("out_counts", 72'({8'(cnt_c5 - c5), 8'(cnt_c16 - c16), 8'(cnt_done - dn)}),
        72'({8'd1, 8'd1, 8'd1}));

    // Watchdog on the token, then on the data packet.
    dn = cnt_done;
    send_cmd(1'b1, 7'd1, 4'd1, 64'h1);
    w = 0;
    tick();
    while (!seq_error && w < 700) begin
      w++;
      tick();
    end
    chk("wd_tok_cycles", 72'(w), 72'd512);
    tick();
    chk("wd_tok_ready", 72'(cmd_ready), 72'd1);
    send_cmd(1'b1, 7'd2, 4'd2, 64'h2);
    repeat (3) tick();
    pulse_done();
    g = 0;
    while (!crc16_pkt_ready && g < 20) begin
      g++;
      tick();
    end
    chk("wd_dat_strobe", 72'(crc16_pkt_ready), 72'd1);
    w = 0;
    tick();
    while (!seq_error && w < 700) begin
      w++;
      tick();
    end
    chk("wd_dat_cycles", 72'(w), 72'd512);
    tick();
    chk("wd_dat_ready", 72'(cmd_ready), 72'd1);
    chk("wd_no_done", 72'(cnt_done - dn), 72'd0);

    // pkt_done on the final timeout cycle is a success.
    er = cnt_err;
    send_cmd(1'b0, 7'd3, 4'd3, 64'h0);
    repeat (512) tick();
    pulse_done();
    chk("edge_seq_done", 72'(seq_done), 72'd1);
    chk("edge_no_error", 72'(cnt_err - er), 72'd0);
    tick();

    // Back-to-back: cmd_valid held high across two commands.
    cmd_is_out = 1'b0;
    cmd_addr   = 7'd3;
    cmd_endp   = 4'd1;
    cmd_valid  = 1'b1;
    w = 0;
    while (!cmd_ready && w < 100) begin
      w++;
      tick();
    end
    tick();
    chk("b2b_a_strobe", 72'(crc5_pkt_ready), 72'd1);
    cmd_addr = 7'd9;
    cmd_endp = 4'd2;
    rdy_seen = 0;
    repeat (5) begin
      if (cmd_ready) rdy_seen++;
      tick();
    end
    pulse_done();
    if (cmd_ready) rdy_seen++;
    chk("b2b_a_done", 72'(seq_done), 72'd1);
    chk("b2b_ready_low", 72'(rdy_seen), 72'd0);
    tick();
    chk("b2b_idle_ready", 72'(cmd_ready), 72'd1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_b_strobe", 72'(crc5_pkt_ready), 72'd1);
    chk("b2b_b_crc5_in", 72'(crc5_pkt_in), 72'(19'b0010_0001001_01101001));
    repeat (3) tick();
    pulse_done();
    chk("b2b_b_done", 72'(seq_done), 72'd1);
    tick();
    chk("strobe_exclusive", 72'(both_hi), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
